// File: rtl/uart_rx.sv
// ---------------------------------------------------------------------------
// uart_rx
//   UART receiver for the far end of our UART transmitter link. The serial
//   line is oversampled PRESCALE times per bit. One frame is recovered per
//   start edge: start(0), WIDTH data bits LSB first, optional parity bit,
//   stop(1). Each bit is decided by a 3-sample majority vote around the bit
//   centre. A good frame updates P_DATA and pulses data_valid for one cycle.
//   A bad parity or stop bit drops the frame and pulses the matching error.
//   RX_IN must already be synchronous to CLK.
//
// Parameters
//   WIDTH      data bits per frame
//   PRESCALE   CLK cycles per bit (even, >= 4)
//
// Ports
//   CLK         in   1      clock, rising edge
//   RST         in   1      asynchronous active-low reset
//   RX_IN       in   1      serial line, idle high
//   PAR_EN      in   1      1 = frame carries a parity bit
//   PAR_TYP     in   1      0 = even parity, 1 = odd parity
//   P_DATA      out  WIDTH  last good received word
//   data_valid  out  1      one-cycle pulse, P_DATA updated with a good frame
//   par_err     out  1      one-cycle pulse, parity mismatch, frame dropped
//   stp_err     out  1      one-cycle pulse, stop bit sampled 0, frame dropped
//   rx_busy     out  1      high while a frame is being received
// ---------------------------------------------------------------------------
module uart_rx #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RX_IN,
  input  logic             PAR_EN,
  input  logic             PAR_TYP,
  output logic [WIDTH-1:0] P_DATA,
  output logic             data_valid,
  output logic             par_err,
  output logic             stp_err,
  output logic             rx_busy
);

  localparam int EC_W = $clog2(PRESCALE);
  localparam int BC_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  // Edge counter positions inside one bit period
  localparam logic [EC_W-1:0] EDGE_S0   = EC_W'(PRESCALE/2 - 1);
  localparam logic [EC_W-1:0] EDGE_S1   = EC_W'(PRESCALE/2);
  localparam logic [EC_W-1:0] EDGE_DEC  = EC_W'(PRESCALE/2 + 1);
  localparam logic [EC_W-1:0] EDGE_LAST = EC_W'(PRESCALE - 1);
  localparam logic [EC_W-1:0] EDGE_ONE  = EC_W'(1);
  localparam logic [BC_W-1:0] BIT_LAST  = BC_W'(WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           r_state;
  logic [EC_W-1:0]  r_edgeCnt;
  logic [BC_W-1:0]  r_bitCnt;
  logic [WIDTH-1:0] r_shift;
  logic [WIDTH-1:0] r_pData;
  logic             r_samp0;
  logic             r_samp1;
  logic             r_parEn;
  logic             r_parTyp;
  logic             r_parBad;
  logic             r_dataValid;
  logic             r_parErr;
  logic             r_stpErr;
  logic             r_busy;

  logic             w_majority;
  logic             w_isDecision;
  logic             w_isLast;
  logic             w_expParity;

  // The third vote is the live line value on the decision cycle, so the
  // bit value is available on the same edge that acts on it.
  assign w_majority   = (r_samp0 & r_samp1) | (r_samp0 & RX_IN) | (r_samp1 & RX_IN);
  assign w_isDecision = (r_edgeCnt == EDGE_DEC);
  assign w_isLast     = (r_edgeCnt == EDGE_LAST);
  assign w_expParity  = r_parTyp ? ~(^r_shift) : (^r_shift);

  assign P_DATA     = r_pData;
  assign data_valid = r_dataValid;
  assign par_err    = r_parErr;
  assign stp_err    = r_stpErr;
  assign rx_busy    = r_busy;

  // First two majority votes, taken just before the bit centre.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_samp0 <= 1'b1;
      r_samp1 <= 1'b1;
    end else if (r_state != IDLE) begin
      if (r_edgeCnt == EDGE_S0) begin
        r_samp0 <= RX_IN;
      end
      if (r_edgeCnt == EDGE_S1) begin
        r_samp1 <= RX_IN;
      end
    end
  end

  // Frame FSM with registered result pulses. The cycle that detects the
  // start edge counts as edge 0, so START is entered with the edge counter
  // already at 1. STOP returns to IDLE at its decision cycle rather than the
  // end of the bit so a start edge following immediately is not missed.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state     <= IDLE;
      r_edgeCnt   <= '0;
      r_bitCnt    <= '0;
      r_shift     <= '0;
      r_pData     <= '0;
      r_parEn     <= 1'b0;
      r_parTyp    <= 1'b0;
      r_parBad    <= 1'b0;
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      r_stpErr    <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_dataValid <= 1'b0;
      r_parErr    <= 1'b0;
      r_stpErr    <= 1'b0;

      case (r_state)
        IDLE: begin
          r_edgeCnt <= '0;
          r_bitCnt  <= '0;
          if (!RX_IN) begin
            r_state   <= START;
            r_edgeCnt <= EDGE_ONE;
            r_parEn   <= PAR_EN;
            r_parTyp  <= PAR_TYP;
            r_parBad  <= 1'b0;
            r_busy    <= 1'b1;
          end
        end

        START: begin
          if (w_isDecision && w_majority) begin
            // Line came back high at the bit centre: a glitch, not a start.
            r_state   <= IDLE;
            r_edgeCnt <= '0;
            r_busy    <= 1'b0;
          end else if (w_isLast) begin
            r_state   <= DATA;
            r_edgeCnt <= '0;
          end else begin
            r_edgeCnt <= r_edgeCnt + 1'b1;
          end
        end

        DATA: begin
          if (w_isDecision) begin
            r_shift[r_bitCnt] <= w_majority;
          end
          if (w_isLast) begin
            r_edgeCnt <= '0;
            if (r_bitCnt == BIT_LAST) begin
              r_bitCnt <= '0;
              r_state  <= r_parEn ? PARITY : STOP;
            end else begin
              r_bitCnt <= r_bitCnt + 1'b1;
            end
          end else begin
            r_edgeCnt <= r_edgeCnt + 1'b1;
          end
        end

        PARITY: begin
          if (w_isDecision) begin
            r_parBad <= (w_majority != w_expParity);
          end
          if (w_isLast) begin
            r_state   <= STOP;
            r_edgeCnt <= '0;
          end else begin
            r_edgeCnt <= r_edgeCnt + 1'b1;
          end
        end

        STOP: begin
          if (w_isDecision) begin
            r_state   <= IDLE;
            r_edgeCnt <= '0;
            r_busy    <= 1'b0;
            if (!w_majority) begin
              r_stpErr <= 1'b1;
              r_parErr <= r_parBad;
            end else if (r_parBad) begin
              r_parErr <= 1'b1;
            end else begin
              r_pData     <= r_shift;
              r_dataValid <= 1'b1;
            end
          end else begin
            r_edgeCnt <= r_edgeCnt + 1'b1;
          end
        end

        default: begin
          r_state   <= IDLE;
          r_edgeCnt <= '0;
          r_bitCnt  <= '0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// ---------------------------------------------------------------------------
// tb_uart_rx
//   Self-checking bench for uart_rx (WIDTH=8, PRESCALE=8). Frames are driven
//   bit by bit; a negedge monitor records every result pulse with its cycle
//   number. Expected outcomes come from a frame-level model: parity from a
//   popcount, pulse latency from the bit count, P_DATA from the last good
//   word.
// ---------------------------------------------------------------------------
module tb_uart_rx;

  localparam int W = 8;
  localparam int P = 8;

  logic         CLK = 1'b0;
  logic         RST = 1'b0;
  logic         RX_IN = 1'b1;
  logic         PAR_EN = 1'b0;
  logic         PAR_TYP = 1'b0;
  logic [W-1:0] P_DATA;
  logic         data_valid;
  logic         par_err;
  logic         stp_err;
  logic         rx_busy;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  int           dvCyc[$];
  logic [W-1:0] dvData[$];
  int           peCyc[$];
  int           seCyc[$];
  int           overlapCnt = 0;
  logic [W-1:0] expData = '0;

  uart_rx #(.WIDTH(W), .PRESCALE(P)) dut (
    .CLK        (CLK),
    .RST        (RST),
    .RX_IN      (RX_IN),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .P_DATA     (P_DATA),
    .data_valid (data_valid),
    .par_err    (par_err),
    .stp_err    (stp_err),
    .rx_busy    (rx_busy)
  );

  // Free-running clock and cycle counter
  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  // Record each pulse with the cycle number of the edge that will see it
  always @(negedge CLK) begin
    if (data_valid) begin
      dvCyc.push_back(cyc + 1);
      dvData.push_back(P_DATA);
    end
    if (par_err) peCyc.push_back(cyc + 1);
    if (stp_err) seCyc.push_back(cyc + 1);
    if (data_valid && (par_err || stp_err)) overlapCnt++;
  end

  // Correct parity bit for a word: even -> popcount odd gives 1
  function automatic logic goodParity(input logic [W-1:0] d, input logic typ);
    return logic'(($countones(d) % 2) != 0) ^ typ;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  task automatic clearMon();
    dvCyc.delete();
    dvData.delete();
    peCyc.delete();
    seCyc.delete();
    overlapCnt = 0;
  endtask

  // One bit period; optionally invert the centre sample only
  task automatic driveBit(input logic val, input bit inv);
    for (int e = 0; e < P; e++) begin
      RX_IN = (inv && e == P/2) ? ~val : val;
      @(posedge CLK);
      #1;
    end
  endtask

  // Drive a whole frame. A low stop bit is released right after its centre
  // so the line is high again when the receiver returns to idle.
  task automatic applyStimulus(input logic [W-1:0] d, input bit parEn, input bit parTyp,
                               input logic parBit, input logic stopBit, input bit inv,
                               output int startCyc);
    PAR_EN = parEn;
    PAR_TYP = parTyp;
    startCyc = cyc + 1;
    driveBit(1'b0, inv);
    for (int i = 0; i < W; i++) driveBit(d[i], inv);
    if (parEn) driveBit(parBit, inv);
    if (stopBit) begin
      driveBit(1'b1, inv);
    end else begin
      for (int e = 0; e < P; e++) begin
        if (e <= P/2 + 1) RX_IN = (inv && e == P/2) ? 1'b1 : 1'b0;
        else              RX_IN = 1'b1;
        @(posedge CLK);
        #1;
      end
    end
    RX_IN = 1'b1;
  endtask

  task automatic checkFrame(input string tag, input logic [W-1:0] d, input bit parEn,
                            input bit parTyp, input logic parBit, input logic stopBit,
                            input int startCyc);
    bit parOk;
    int expDv, expPe, expSe, lat, obsLat;
    parOk = !parEn || (parBit == goodParity(d, parTyp));
    expDv = (stopBit && parOk) ? 1 : 0;
    expSe = stopBit ? 0 : 1;
    expPe = parOk ? 0 : 1;
    lat = (1 + W + (parEn ? 1 : 0)) * P + P/2 + 2;
    if (expDv == 1) expData = d;
    obsLat = -1;
    if (seCyc.size() > 0)      obsLat = seCyc[0] - startCyc;
    else if (peCyc.size() > 0) obsLat = peCyc[0] - startCyc;
    else if (dvCyc.size() > 0) obsLat = dvCyc[0] - startCyc;
    checkOutput({tag, " data_valid count"}, dvCyc.size(), expDv);
    checkOutput({tag, " par_err count"}, peCyc.size(), expPe);
    checkOutput({tag, " stp_err count"}, seCyc.size(), expSe);
    checkOutput({tag, " pulse latency"}, obsLat, lat);
    checkOutput({tag, " P_DATA"}, 32'(P_DATA), 32'(expData));
    checkOutput({tag, " rx_busy idle"}, 32'(rx_busy), 32'd0);
    checkOutput({tag, " pulse overlap"}, overlapCnt, 0);
  endtask

  task automatic runFrame(input string tag, input logic [W-1:0] d, input bit parEn,
                          input bit parTyp, input logic parBit, input logic stopBit,
                          input bit inv);
    int st;
    clearMon();
    applyStimulus(d, parEn, parTyp, parBit, stopBit, inv, st);
    waitCycles(3);
    checkFrame(tag, d, parEn, parTyp, parBit, stopBit, st);
  endtask

  // Directed steps followed by a randomized frame loop
  initial begin
    int st1, st2;
    logic [W-1:0] rd;
    logic [W-1:0] partial;
    bit rParEn, rParTyp, rInv;
    logic rParBit, rStop;

    $display("[TB] uart_rx bench start");
    RST = 1'b0;
    waitCycles(3);
    checkOutput("reset P_DATA", 32'(P_DATA), 32'd0);
    checkOutput("reset data_valid", 32'(data_valid), 32'd0);
    checkOutput("reset par_err", 32'(par_err), 32'd0);
    checkOutput("reset stp_err", 32'(stp_err), 32'd0);
    checkOutput("reset rx_busy", 32'(rx_busy), 32'd0);
    RST = 1'b1;
    waitCycles(4);

    runFrame("t1 A5 nopar", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    runFrame("t2 3C even ok", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    runFrame("t2 3C even bad", 8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
    runFrame("t3 01 stop0", 8'h01, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    runFrame("t3 01 stop0 badpar", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    runFrame("t3 55 odd ok", 8'h55, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0);

    // Two-cycle low glitch on the idle line
    clearMon();
    RX_IN = 1'b0;
    waitCycles(2);
    RX_IN = 1'b1;
    checkOutput("t4 rx_busy during glitch", 32'(rx_busy), 32'd1);
    waitCycles(4);
    checkOutput("t4 rx_busy at cycle 6", 32'(rx_busy), 32'd0);
    waitCycles(20);
    checkOutput("t4 pulses after glitch", dvCyc.size() + peCyc.size() + seCyc.size(), 0);
    checkOutput("t4 P_DATA kept", 32'(P_DATA), 32'(expData));

    // Back-to-back frames with no idle gap
    clearMon();
    applyStimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st1);
    applyStimulus(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, st2);
    waitCycles(3);
    checkOutput("t5 data_valid count", dvCyc.size(), 2);
    checkOutput("t5 first latency", (dvCyc.size() > 0) ? dvCyc[0] - st1 : -1, (1 + W) * P + P/2 + 2);
    checkOutput("t5 pulse spacing", (dvCyc.size() > 1) ? dvCyc[1] - dvCyc[0] : -1, (W + 2) * P);
    checkOutput("t5 first word", (dvData.size() > 0) ? 32'(dvData[0]) : 32'hFFFF_FFFF, 32'h00);
    checkOutput("t5 second word", (dvData.size() > 1) ? 32'(dvData[1]) : 32'hFFFF_FFFF, 32'hFF);
    checkOutput("t5 error pulses", peCyc.size() + seCyc.size(), 0);
    expData = 8'hFF;

    // Centre sample inverted on every bit
    runFrame("t6 96 inverted mid", 8'h96, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of the data bits
    clearMon();
    partial = 8'h96;
    PAR_EN = 1'b0;
    driveBit(1'b0, 1'b0);
    for (int i = 0; i < 3; i++) driveBit(partial[i], 1'b0);
    RX_IN = 1'b1;
    #2;
    RST = 1'b0;
    #1;
    expData = '0;
    checkOutput("t6 reset P_DATA", 32'(P_DATA), 32'd0);
    checkOutput("t6 reset rx_busy", 32'(rx_busy), 32'd0);
    checkOutput("t6 reset data_valid", 32'(data_valid), 32'd0);
    waitCycles(3);
    RST = 1'b1;
    waitCycles(3);
    checkOutput("t6 after reset pulses", dvCyc.size() + peCyc.size() + seCyc.size(), 0);
    runFrame("t6 5A after reset", 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);

    // Random frames, mostly good with some parity and stop faults
    for (int n = 0; n < 16; n++) begin
      rd      = W'($urandom_range(0, 255));
      rParEn  = 1'($urandom_range(0, 1));
      rParTyp = 1'($urandom_range(0, 1));
      rParBit = goodParity(rd, rParTyp) ^ ($urandom_range(0, 3) == 0);
      rStop   = ($urandom_range(0, 3) != 0);
      rInv    = 1'($urandom_range(0, 1));
      runFrame($sformatf("rand%0d", n), rd, rParEn, rParTyp, rParBit, rStop, rInv);
      waitCycles($urandom_range(0, 5));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
